// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the program counter, drives a synchronous
// instruction memory with one-cycle read latency and loads the IF/ID register
// that feeds Decode. A one-entry skid buffer catches the word already in
// flight when Decode stalls. Branches redirect fetch, and a HALT opcode
// freezes fetch until a branch or reset.
module instruction_fetch #(
  parameter int unsigned         INSTRUCTION_WIDTH = 30,
  parameter int unsigned         PC_WIDTH          = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC          = '0,
  parameter logic [4:0]          HALT_OPCODE       = 5'b11111
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         stall,
  input  logic                         branchTaken,
  input  logic [PC_WIDTH-1:0]          branchTarget,
  output logic [PC_WIDTH-1:0]          imemAddress,
  input  logic [INSTRUCTION_WIDTH-1:0] imemReadData,
  output logic [INSTRUCTION_WIDTH-1:0] instruction,
  output logic [PC_WIDTH-1:0]          instructionPC,
  output logic                         instructionValid,
  output logic                         halted
);

  // RUN: normal streaming; HOLD: skid buffer occupied while Decode stalls;
  // HALT: fetch frozen after a HALT word has issued.
  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HOLD = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  localparam logic [INSTRUCTION_WIDTH-1:0] NOP    = '0;
  localparam logic [PC_WIDTH-1:0]          PC_ONE = PC_WIDTH'(1);

  state_e                         state_q, state_d;

  // Next address to request from memory.
  logic [PC_WIDTH-1:0]            pc_q, pc_d;

  // Address and validity of the word currently on imemReadData.
  logic [PC_WIDTH-1:0]            fetch_pc_q, fetch_pc_d;
  logic                           fetch_valid_q, fetch_valid_d;

  // Skid buffer for the word that arrived while Decode was stalled.
  logic [INSTRUCTION_WIDTH-1:0]   hold_instr_q, hold_instr_d;
  logic [PC_WIDTH-1:0]            hold_pc_q, hold_pc_d;
  logic                           hold_valid_q, hold_valid_d;

  // IF/ID pipeline register.
  logic [INSTRUCTION_WIDTH-1:0]   if_instr_q, if_instr_d;
  logic [PC_WIDTH-1:0]            if_pc_q, if_pc_d;
  logic                           if_valid_q, if_valid_d;

  // A word entering IF/ID stops fetch only if it is real and carries HALT.
  function automatic logic is_halt(input logic                         valid,
                                   input logic [INSTRUCTION_WIDTH-1:0] word);
    return valid && (word[INSTRUCTION_WIDTH-1 -: 5] == HALT_OPCODE);
  endfunction

  // Next-state and IF/ID load decisions; redirect beats stall beats streaming.
  always_comb begin
    // NOTE: every signal written here gets a hold default first, so no path
    // can leave one unassigned and infer a latch.
    state_d       = state_q;
    pc_d          = pc_q;
    fetch_pc_d    = fetch_pc_q;
    fetch_valid_d = fetch_valid_q;
    hold_instr_d  = hold_instr_q;
    hold_pc_d     = hold_pc_q;
    hold_valid_d  = hold_valid_q;
    if_instr_d    = if_instr_q;
    if_pc_d       = if_pc_q;
    if_valid_d    = if_valid_q;

    if (branchTaken) begin
      // Squash everything in flight; the word on the bus belongs to the old
      // path, so the fetch slot is marked empty and IF/ID becomes a bubble.
      pc_d          = branchTarget;
      fetch_valid_d = 1'b0;
      hold_valid_d  = 1'b0;
      if_instr_d    = NOP;
      if_valid_d    = 1'b0;
      state_d       = ST_RUN;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (stall) begin
            // Park the arriving word; memory then re-reads pc so the bus keeps
            // showing the word for the new fetch_pc until the stall ends.
            hold_instr_d  = imemReadData;
            hold_pc_d     = fetch_pc_q;
            hold_valid_d  = fetch_valid_q;
            fetch_pc_d    = pc_q;
            fetch_valid_d = 1'b1;
            state_d       = ST_HOLD;
          end else begin
            if_instr_d    = fetch_valid_q ? imemReadData : NOP;
            if_pc_d       = fetch_pc_q;
            if_valid_d    = fetch_valid_q;
            fetch_pc_d    = pc_q;
            fetch_valid_d = 1'b1;
            pc_d          = pc_q + PC_ONE;
            if (is_halt(fetch_valid_q, imemReadData)) begin
              state_d = ST_HALT;
            end
          end
        end

        ST_HOLD: begin
          if (!stall) begin
            // Drain the skid buffer; the word on the bus is for pc and is
            // simply requested again this edge.
            if_instr_d = hold_valid_q ? hold_instr_q : NOP;
            if_pc_d    = hold_pc_q;
            if_valid_d = hold_valid_q;
            fetch_pc_d = pc_q;
            pc_d       = pc_q + PC_ONE;
            state_d    = ST_RUN;
            if (is_halt(hold_valid_q, hold_instr_q)) begin
              state_d = ST_HALT;
            end
          end
        end

        ST_HALT: begin
          // The HALT word stays visible while Decode is stalled on it.
          fetch_valid_d = 1'b0;
          if (!stall) begin
            if_instr_d = NOP;
            if_valid_d = 1'b0;
          end
        end

        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

  // All stage state, cleared asynchronously while reset is low.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_RUN;
      pc_q          <= RESET_PC;
      fetch_pc_q    <= '0;
      fetch_valid_q <= 1'b0;
      hold_instr_q  <= '0;
      hold_pc_q     <= '0;
      hold_valid_q  <= 1'b0;
      if_instr_q    <= '0;
      if_pc_q       <= '0;
      if_valid_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every register samples the pre-edge
      // values regardless of statement order.
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_pc_q    <= fetch_pc_d;
      fetch_valid_q <= fetch_valid_d;
      hold_instr_q  <= hold_instr_d;
      hold_pc_q     <= hold_pc_d;
      hold_valid_q  <= hold_valid_d;
      if_instr_q    <= if_instr_d;
      if_pc_q       <= if_pc_d;
      if_valid_q    <= if_valid_d;
    end
  end

  assign imemAddress      = pc_q;
  assign instruction      = if_instr_q;
  assign instructionPC    = if_pc_q;
  assign instructionValid = if_valid_q;
  assign halted           = (state_q == ST_HALT);

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed stimulus pushes the expected IF/ID
// stream into a queue; a monitor pops and compares every word IF/ID loads.
// A second instance starting near the top of the address space covers wrap.
module tb_instruction_fetch;

  typedef struct {
    logic [29:0] word;
    logic [15:0] pc;
  } exp_t;

  localparam logic [29:0] HALT_WORD_3 = 30'h3E00_0003;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall;
  logic        branchTaken;
  logic [15:0] branchTarget;
  logic [15:0] imemAddress;
  logic [29:0] imemReadData;
  logic [29:0] instruction;
  logic [15:0] instructionPC;
  logic        instructionValid;
  logic        halted;

  logic        stall2;
  logic        branch2;
  logic [15:0] target2;
  logic [15:0] imem_addr2;
  logic [29:0] imem_data2;
  logic [29:0] instr2;
  logic [15:0] instr_pc2;
  logic        instr_valid2;
  logic        halted2;

  logic [15:0] halt_addr;
  logic        took;
  int          errors = 0;
  int          checks = 0;
  exp_t        q1[$];
  exp_t        q2[$];

  always #5 clock = ~clock;

  instruction_fetch dut (
    .clock            (clock),
    .reset            (reset),
    .stall            (stall),
    .branchTaken      (branchTaken),
    .branchTarget     (branchTarget),
    .imemAddress      (imemAddress),
    .imemReadData     (imemReadData),
    .instruction      (instruction),
    .instructionPC    (instructionPC),
    .instructionValid (instructionValid),
    .halted           (halted)
  );

  instruction_fetch #(.RESET_PC(16'hFFFE)) dut_wrap (
    .clock            (clock),
    .reset            (reset),
    .stall            (stall2),
    .branchTaken      (branch2),
    .branchTarget     (target2),
    .imemAddress      (imem_addr2),
    .imemReadData     (imem_data2),
    .instruction      (instr2),
    .instructionPC    (instr_pc2),
    .instructionValid (instr_valid2),
    .halted           (halted2)
  );

  // Memory contents: 0x100 + address, except a HALT word at halt_addr.
  function automatic logic [29:0] mem_word(input logic [15:0] a);
    if (a == halt_addr) return {5'b11111, 25'(a)};
    return 30'h100 + 30'(a);
  endfunction

  always @(posedge clock) imemReadData <= mem_word(imemAddress);
  always @(posedge clock) imem_data2   <= 30'h100 + 30'(imem_addr2);

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic push_seq(input logic [15:0] start, input int n);
    for (int i = 0; i < n; i++) begin
      q1.push_back('{word: 30'h100 + 30'(start + 16'(i)), pc: start + 16'(i)});
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // IF/ID takes new contents at an edge unless a stall without redirect.
  always @(posedge clock) took <= branchTaken || !stall;

  // Scoreboard monitor for the main instance.
  always @(negedge clock) begin
    if (reset && took && instructionValid) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got pc %h word %h with nothing expected",
                 instructionPC, instruction);
      end else begin
        exp_t e;
        e = q1.pop_front();
        check("ifid_pc", 32'(instructionPC), 32'(e.pc));
        check("ifid_word", 32'(instruction), 32'(e.word));
      end
    end
  end

  // Monitor for the wrap instance: checks only the queued start of its stream.
  always @(negedge clock) begin
    if (reset && instr_valid2 && q2.size() != 0) begin
      exp_t e;
      e = q2.pop_front();
      check("wrap_pc", 32'(instr_pc2), 32'(e.pc));
      check("wrap_word", 32'(instr2), 32'(e.word));
    end
  end

  initial begin
    reset        = 1'b0;
    stall        = 1'b0;
    branchTaken  = 1'b0;
    branchTarget = 16'h0000;
    stall2       = 1'b0;
    branch2      = 1'b0;
    target2      = 16'h0000;
    halt_addr    = 16'hFFF0;

    // Reset held for 3 cycles.
    step(3);
    check("rst_instr", 32'(instruction), 32'h0);
    check("rst_pc", 32'(instructionPC), 32'h0);
    check("rst_valid", 32'(instructionValid), 32'h0);
    check("rst_halted", 32'(halted), 32'h0);
    check("rst_addr", 32'(imemAddress), 32'h0);

    // Stream from PC 0; stalls below must neither drop nor repeat words.
    push_seq(16'h0000, 10);
    q2.push_back('{word: 30'h0100FE, pc: 16'hFFFE});
    q2.push_back('{word: 30'h0100FF, pc: 16'hFFFF});
    q2.push_back('{word: 30'h000100, pc: 16'h0000});
    reset = 1'b1;
    step(1);
    check("first_edge_valid", 32'(instructionValid), 32'h0);
    step(5);
    check("pre_stall_pc", 32'(instructionPC), 32'h4);

    // Three-cycle stall with PC 4 in IF/ID.
    stall = 1'b1;
    step(3);
    check("stall_hold_pc", 32'(instructionPC), 32'h4);
    check("stall_hold_valid", 32'(instructionValid), 32'h1);
    stall = 1'b0;
    step(2);

    // Single-cycle stall, then alternating 1,0,1,0.
    stall = 1'b1;
    step(1);
    stall = 1'b0;
    step(1);
    stall = 1'b1;
    step(1);
    stall = 1'b0;
    step(1);
    stall = 1'b1;
    step(1);
    stall = 1'b0;
    step(1);
    check("pre_branch_pc", 32'(instructionPC), 32'h9);

    // Branch to 0x40 while PC 9 sits in IF/ID.
    push_seq(16'h0040, 2);
    branchTaken  = 1'b1;
    branchTarget = 16'h0040;
    step(1);
    branchTaken = 1'b0;
    check("branch_bubble_valid", 32'(instructionValid), 32'h0);
    check("branch_bubble_pc", 32'(instructionPC), 32'h9);
    step(3);

    // Branch together with stall while in HOLD: skid buffer must be dropped.
    stall = 1'b1;
    step(2);
    check("hold_pc", 32'(instructionPC), 32'h41);
    push_seq(16'h0080, 3);
    branchTaken  = 1'b1;
    branchTarget = 16'h0080;
    step(1);
    branchTaken = 1'b0;
    stall       = 1'b0;
    check("hold_branch_valid", 32'(instructionValid), 32'h0);
    step(4);

    // HALT word at PC 3.
    halt_addr = 16'h0003;
    push_seq(16'h0000, 3);
    q1.push_back('{word: HALT_WORD_3, pc: 16'h0003});
    branchTaken  = 1'b1;
    branchTarget = 16'h0000;
    step(1);
    branchTaken = 1'b0;
    step(5);
    check("halt_flag", 32'(halted), 32'h1);
    check("halt_word", 32'(instruction), 32'(HALT_WORD_3));
    check("halt_addr", 32'(imemAddress), 32'h5);
    stall = 1'b1;
    step(1);
    check("halt_stall_valid", 32'(instructionValid), 32'h1);
    stall = 1'b0;
    step(1);
    check("halt_nop_valid", 32'(instructionValid), 32'h0);
    check("halt_nop_word", 32'(instruction), 32'h0);
    step(1);
    check("halt_frozen_addr", 32'(imemAddress), 32'h5);
    check("halt_still", 32'(halted), 32'h1);

    // Branch to 0 restarts fetch.
    halt_addr = 16'hFFF0;
    push_seq(16'h0000, 3);
    branchTaken  = 1'b1;
    branchTarget = 16'h0000;
    step(1);
    branchTaken = 1'b0;
    check("restart_halted", 32'(halted), 32'h0);
    step(4);

    // Asynchronous reset between edges while in HOLD.
    stall = 1'b1;
    step(1);
    #2;
    reset = 1'b0;
    #1;
    check("async_instr", 32'(instruction), 32'h0);
    check("async_pc", 32'(instructionPC), 32'h0);
    check("async_valid", 32'(instructionValid), 32'h0);
    check("async_halted", 32'(halted), 32'h0);
    check("async_addr", 32'(imemAddress), 32'h0);
    step(2);
    stall = 1'b0;
    reset = 1'b1;
    push_seq(16'h0000, 3);
    step(4);
    stall = 1'b1;
    #10;

    check("q1_drained", 32'(q1.size()), 32'h0);
    check("q2_drained", 32'(q2.size()), 32'h0);
    check("wrap_not_halted", 32'(halted2), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
